// File: rtl/light_phase_monitor_if.sv
// Light color type shared with the controller, plus the record handshake
// interface carrying {color, duration} records to a consumer.
package light_pkg;
  typedef enum logic [1:0] {RED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2} light_t;
endpackage

interface light_phase_monitor_if #(parameter int DUR_W = 8);
  import light_pkg::*;

  logic             rec_valid;
  logic             rec_ready;
  light_t           rec_color;
  logic [DUR_W-1:0] rec_dur;

  modport master (output rec_valid, rec_color, rec_dur, input rec_ready);
  modport slave  (input rec_valid, rec_color, rec_dur, output rec_ready);
endinterface

// File: rtl/light_phase_monitor.sv
// Measures each light phase, checks the RED->GREEN->YELLOW->RED order and
// queues one {color, duration} record per completed phase in a show-ahead FIFO.
module light_phase_monitor
  import light_pkg::*;
#(
  parameter int DUR_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_DUR    = 200
) (
  input  logic                          clk,
  input  logic                          rst,
  input  light_t                        color,
  light_phase_monitor_if.master         rec,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   cycle_count,
  output logic                          seq_err,
  output logic                          timeout,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [DUR_W-1:0]          DUR_SAT   = '1;
  localparam logic [DUR_W:0]            TIMEOUT_V = (DUR_W+1)'(MAX_DUR);
  localparam logic [$clog2(FIFO_DEPTH):0] FULL_LVL = ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH);

  logic             armed;
  light_t           cur;
  logic [DUR_W-1:0] dur;
  logic [DUR_W:0]   dur_inc;

  light_t           mem_color [FIFO_DEPTH];
  logic [DUR_W-1:0] mem_dur   [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic color_ok, boundary, legal, full, push, pop;

  always_comb begin
    color_ok = (color == RED) || (color == GREEN) || (color == YELLOW);
    boundary = armed && color_ok && (color != cur);
    legal    = ((cur == RED)    && (color == GREEN))  ||
               ((cur == GREEN)  && (color == YELLOW)) ||
               ((cur == YELLOW) && (color == RED));
    dur_inc  = {1'b0, dur} + 1'b1;
    full     = (fifo_level == FULL_LVL);
    pop      = rec.rec_valid && rec.rec_ready;
    // A full FIFO can still accept a record when the head leaves on the same edge.
    push     = boundary && (!full || pop);
  end

  // Empty FIFO presents a neutral head rather than stale storage.
  assign rec.rec_valid = (fifo_level != '0);
  assign rec.rec_color = rec.rec_valid ? mem_color[rd_ptr] : RED;
  assign rec.rec_dur   = rec.rec_valid ? mem_dur[rd_ptr]   : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      armed       <= 1'b0;
      cur         <= RED;
      dur         <= '0;
      cycle_count <= '0;
      seq_err     <= 1'b0;
      timeout     <= 1'b0;
      overflow    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
    end else begin
      if (!armed) begin
        cur   <= color;
        dur   <= DUR_W'(1);
        armed <= 1'b1;
      end else if (!color_ok) begin
        seq_err <= 1'b1;
      end else if (color == cur) begin
        if (dur != DUR_SAT) dur <= dur_inc[DUR_W-1:0];
        if (dur_inc == TIMEOUT_V) timeout <= 1'b1;
      end else begin
        if (!legal) seq_err <= 1'b1;
        if ((cur == YELLOW) && (color == RED)) cycle_count <= cycle_count + 16'd1;
        cur <= color;
        dur <= DUR_W'(1);
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;
      if (boundary && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_color[wr_ptr] <= cur;
      mem_dur[wr_ptr]   <= dur;
    end
  end

endmodule
